// File: rtl/hcu_pkg.sv
// Shared definitions for the hazard control unit: FSM state type and the
// encodings of the DE-stage operand forwarding mux select.
package hcu_pkg;

   // IDLE watches for hazards and branches; FLUSH walks through the
   // post-branch bubble window.
   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } hcuState_t;

   // DE operand mux selects: register file, WR-stage result, EXWM-stage result.
   localparam logic [1:0] SEL_RF = 2'b00;
   localparam logic [1:0] SEL_WR = 2'b01;
   localparam logic [1:0] SEL_EX = 2'b10;

endpackage

// File: rtl/hcu_src_cmp.sv
// Per-source operand comparator. Decides whether one DE source operand is
// produced by the instruction in EXWM or in WR. It also decides whether the
// copy of that operand now sitting in EXWM must take the WR result.
// Register x0 and unused operands never match, so no forward or stall is
// ever raised for them.
module hcu_src_cmp #(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] deRs,
   input  logic              deRsUsed,
   input  logic              exwmRWE,
   input  logic [REG_AW-1:0] exwmRd,
   input  logic              wrRWE,
   input  logic [REG_AW-1:0] wrRd,
   input  logic [REG_AW-1:0] exwmRs,
   input  logic              exwmUsed,
   output logic              mex,
   output logic              mwr,
   output logic              exwmWrSel
);

   logic deLive;
   logic exLive;

   // An operand only takes part in matching when it is really read and is
   // not the hard-wired zero register.
   assign deLive    = deRsUsed && (deRs != '0);
   assign exLive    = exwmUsed && (exwmRs != '0);

   assign mex       = deLive && exwmRWE && (exwmRd == deRs);
   assign mwr       = deLive && wrRWE   && (wrRd   == deRs);
   assign exwmWrSel = exLive && wrRWE   && (wrRd   == exwmRs);

endmodule

// File: rtl/hcu_param.sv
// Parametrised hazard control unit for the IF/DE/EXWM/WR pipeline.
// It drives the flush/hold controls of the pipeline registers and the operand
// forwarding muxes. It also keeps saturating stall/flush event counters for
// the debug bus.
module hcu_param
   import hcu_pkg::*;
#(
   parameter int REG_AW          = 5,
   parameter int NUM_SRC         = 2,
   parameter int BR_FLUSH_CYCLES = 3,
   parameter int FWD_EX          = 1,
   parameter int CNT_W           = 16
) (
   input  logic                      CLK,
   input  logic                      rst,
   input  logic                      DEBranchFlush,
   input  logic [NUM_SRC*REG_AW-1:0] DErs,
   input  logic [NUM_SRC-1:0]        DErsUsed,
   input  logic                      EXWMRWE,
   input  logic                      EXWMLoad,
   input  logic [REG_AW-1:0]         EXWMrd,
   input  logic                      WRRWE,
   input  logic [REG_AW-1:0]         WRrd,
   output logic                      IFFlush,
   output logic                      DEFlush,
   output logic                      IFStall,
   output logic [2*NUM_SRC-1:0]      DEMuxS,
   output logic [NUM_SRC-1:0]        EXWMMuxS,
   output logic [CNT_W-1:0]          StallCnt,
   output logic [CNT_W-1:0]          FlushCnt
);

   localparam int   FC_W   = $clog2(BR_FLUSH_CYCLES + 1);
   localparam logic NO_FWD = (FWD_EX == 0);

   hcuState_t                 state;
   logic [FC_W-1:0]           fc;
   logic [NUM_SRC*REG_AW-1:0] exwmRs;
   logic [NUM_SRC-1:0]        exwmUsed;

   logic [NUM_SRC-1:0]        mex;
   logic [NUM_SRC-1:0]        mwr;
   logic [NUM_SRC-1:0]        hazard;
   logic [NUM_SRC-1:0]        exwmSel;
   logic [2*NUM_SRC-1:0]      demuxRaw;
   logic                      hz;
   logic                      branchAccept;

   for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
      hcu_src_cmp #(
         .REG_AW(REG_AW)
      ) uCmp (
         .deRs     (DErs[i*REG_AW +: REG_AW]),
         .deRsUsed (DErsUsed[i]),
         .exwmRWE  (EXWMRWE),
         .exwmRd   (EXWMrd),
         .wrRWE    (WRRWE),
         .wrRd     (WRrd),
         .exwmRs   (exwmRs[i*REG_AW +: REG_AW]),
         .exwmUsed (exwmUsed[i]),
         .mex      (mex[i]),
         .mwr      (mwr[i]),
         .exwmWrSel(exwmSel[i])
      );

      // An EXWM match can be forwarded only if the result already exists,
      // i.e. it is not a load and forwarding from EXWM is enabled.
      assign hazard[i] = mex[i] && (EXWMLoad || NO_FWD);

      // EXWM has priority over WR because it holds the younger write.
      assign demuxRaw[2*i +: 2] = (mex[i] && !hazard[i]) ? SEL_EX :
                                  mwr[i]                 ? SEL_WR : SEL_RF;
   end

   assign hz           = |hazard;
   assign branchAccept = (state == IDLE) && DEBranchFlush && !hz;

   // All outputs are decoded without delay from the current state and inputs.
   // Everything is forced low while reset is held, so the pipeline sees
   // neutral controls during reset. In FLUSH the hazard and branch inputs do
   // not matter. IF is killed for all but the last cycle of the window, so
   // the flush pattern lines up one cycle behind in DE.
   always_comb begin
      IFFlush  = 1'b0;
      DEFlush  = 1'b0;
      IFStall  = 1'b0;
      DEMuxS   = '0;
      EXWMMuxS = '0;
      if (!rst) begin
         if (state == FLUSH) begin
            DEFlush = 1'b1;
            IFFlush = (fc > FC_W'(1));
         end else begin
            IFStall = hz;
            DEFlush = hz;
            IFFlush = DEBranchFlush && !hz;
         end
         DEMuxS   = demuxRaw;
         EXWMMuxS = exwmSel;
      end
   end

   // Branch flush sequencer and event counters. A branch that arrives
   // together with a hazard is not accepted. The stall holds the branch in
   // DE, so it is seen again once the hazard clears. Both counters stop at
   // all-ones and do not wrap. A stale count would confuse the debug side
   // more than a saturated one.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         fc       <= '0;
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (branchAccept) begin
                  state <= FLUSH;
                  fc    <= FC_W'(BR_FLUSH_CYCLES);
                  if (FlushCnt != '1) begin
                     FlushCnt <= FlushCnt + CNT_W'(1);
                  end
               end
               if (hz && (StallCnt != '1)) begin
                  StallCnt <= StallCnt + CNT_W'(1);
               end
            end
            FLUSH: begin
               fc <= fc - FC_W'(1);
               if (fc == FC_W'(1)) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The DE source addresses and their "used" bits move into EXWM with the
   // instruction. A bubble inserted by DEFlush carries no live operands. This
   // stops a squashed instruction from steering the EXWM forwarding mux.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         exwmRs   <= '0;
         exwmUsed <= '0;
      end else begin
         exwmRs   <= DErs;
         exwmUsed <= DErsUsed & {NUM_SRC{~DEFlush}};
      end
   end

endmodule

// File: tb/tb_hcu_param.sv
// Bench for hcu_param. It runs a table of single-cycle hazard/forwarding
// vectors, hand-written multi-cycle sequences (load-use, branch window,
// branch versus hazard, saturation, reset mid-flush), and a randomized run
// checked against a cycle-count based reference model.
module tb_hcu_param;

   localparam int REG_AW  = 5;
   localparam int NUM_SRC = 2;
   localparam int BR      = 3;
   localparam int FWD_EX  = 1;
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic                      CLK = 1'b0;
   logic                      rst = 1'b1;
   logic                      DEBranchFlush;
   logic [NUM_SRC*REG_AW-1:0] DErs;
   logic [NUM_SRC-1:0]        DErsUsed;
   logic                      EXWMRWE;
   logic                      EXWMLoad;
   logic [REG_AW-1:0]         EXWMrd;
   logic                      WRRWE;
   logic [REG_AW-1:0]         WRrd;
   logic                      IFFlush;
   logic                      DEFlush;
   logic                      IFStall;
   logic [2*NUM_SRC-1:0]      DEMuxS;
   logic [NUM_SRC-1:0]        EXWMMuxS;
   logic [CNT_W-1:0]          StallCnt;
   logic [CNT_W-1:0]          FlushCnt;

   int vectorCount = 0;
   int missCount   = 0;

   typedef struct {
      logic       br;
      logic [4:0] rs0;
      logic [4:0] rs1;
      logic [1:0] used;
      logic       exRWE;
      logic       exLoad;
      logic [4:0] exRd;
      logic       wrRWE;
      logic [4:0] wrRd;
      logic [3:0] eMux;
      logic       eStall;
      logic       eDEFlush;
      logic       eIFFlush;
   } vec_t;

   vec_t tbl [12];

   hcu_param #(
      .REG_AW         (REG_AW),
      .NUM_SRC        (NUM_SRC),
      .BR_FLUSH_CYCLES(BR),
      .FWD_EX         (FWD_EX),
      .CNT_W          (CNT_W)
   ) dut (
      .CLK          (CLK),
      .rst          (rst),
      .DEBranchFlush(DEBranchFlush),
      .DErs         (DErs),
      .DErsUsed     (DErsUsed),
      .EXWMRWE      (EXWMRWE),
      .EXWMLoad     (EXWMLoad),
      .EXWMrd       (EXWMrd),
      .WRRWE        (WRRWE),
      .WRrd         (WRrd),
      .IFFlush      (IFFlush),
      .DEFlush      (DEFlush),
      .IFStall      (IFStall),
      .DEMuxS       (DEMuxS),
      .EXWMMuxS     (EXWMMuxS),
      .StallCnt     (StallCnt),
      .FlushCnt     (FlushCnt)
   );

   // Free-running clock, period 10.
   always #5 CLK = ~CLK;

   task automatic applyStimulus(input logic br, input logic [4:0] rs0, input logic [4:0] rs1,
                                input logic [1:0] used, input logic exRWE, input logic exLoad,
                                input logic [4:0] exRd, input logic wrRWE, input logic [4:0] wrRd);
      DEBranchFlush = br;
      DErs          = {rs1, rs0};
      DErsUsed      = used;
      EXWMRWE       = exRWE;
      EXWMLoad      = exLoad;
      EXWMrd        = exRd;
      WRRWE         = wrRWE;
      WRrd          = wrRd;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      @(negedge CLK);
      rst = 1'b0;
   endtask

   initial begin
      int         cyc;
      int         acceptCyc;
      int         sinceAcc;
      int         stallCount;
      int         flushCount;
      int         expMux;
      int         expExMux;
      bit         inFlush;
      bit         hzm;
      bit         accept;
      bit         expStall;
      bit         expDEFl;
      bit         expIFFl;
      logic [4:0] prevRs [NUM_SRC];
      bit         prevUsed [NUM_SRC];
      logic [4:0] srcA [NUM_SRC];
      logic       rbr;
      logic [1:0] ru;
      logic       eR;
      logic       eL;
      logic [4:0] eD;
      logic       wR;
      logic [4:0] wD;

      // Reset state: matching inputs while reset is held must give zero outputs.
      applyStimulus(1, 5, 5, 2'b11, 1, 0, 5, 1, 5);
      #2;
      checkOutput("rst.IFFlush",  IFFlush,  0);
      checkOutput("rst.DEFlush",  DEFlush,  0);
      checkOutput("rst.IFStall",  IFStall,  0);
      checkOutput("rst.DEMuxS",   DEMuxS,   0);
      checkOutput("rst.EXWMMuxS", EXWMMuxS, 0);
      checkOutput("rst.StallCnt", StallCnt, 0);
      checkOutput("rst.FlushCnt", FlushCnt, 0);

      // Single-cycle vectors, each applied fresh out of reset.
      tbl[0]  = '{1'b0, 5'd5, 5'd0,  2'b01, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0,  4'b0010, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 5'd5, 5'd0,  2'b01, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0,  4'b0000, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 5'd0, 5'd0,  2'b01, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0,  4'b0000, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 5'd3, 5'd7,  2'b01, 1'b1, 1'b0, 5'd7, 1'b1, 5'd7,  4'b0000, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 5'd0, 5'd12, 2'b10, 1'b0, 1'b0, 5'd0, 1'b1, 5'd12, 4'b0100, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 5'd6, 5'd6,  2'b11, 1'b1, 1'b0, 5'd6, 1'b1, 5'd6,  4'b1010, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 5'd0, 5'd6,  2'b10, 1'b1, 1'b1, 5'd6, 1'b1, 5'd6,  4'b0100, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 5'd0, 5'd0,  2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  4'b0000, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 5'd5, 5'd0,  2'b01, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0,  4'b0000, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 5'd5, 5'd0,  2'b01, 1'b0, 1'b0, 5'd5, 1'b0, 5'd0,  4'b0000, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 5'd9, 5'd9,  2'b11, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9,  4'b0000, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 5'd0, 5'd0,  2'b01, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0,  4'b0000, 1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 12; i++) begin
         doReset();
         applyStimulus(tbl[i].br, tbl[i].rs0, tbl[i].rs1, tbl[i].used, tbl[i].exRWE,
                       tbl[i].exLoad, tbl[i].exRd, tbl[i].wrRWE, tbl[i].wrRd);
         #1;
         checkOutput($sformatf("tbl%0d.DEMuxS", i),  DEMuxS,  tbl[i].eMux);
         checkOutput($sformatf("tbl%0d.IFStall", i), IFStall, tbl[i].eStall);
         checkOutput($sformatf("tbl%0d.DEFlush", i), DEFlush, tbl[i].eDEFlush);
         checkOutput($sformatf("tbl%0d.IFFlush", i), IFFlush, tbl[i].eIFFlush);
      end

      // Load-use: one stall cycle, then WR forwarding. The bubble's operand
      // must not drive the EXWM mux; the next real instruction must.
      doReset();
      applyStimulus(0, 5, 0, 2'b01, 1, 1, 5, 0, 0);
      #1;
      checkOutput("lu.IFStall", IFStall, 1);
      checkOutput("lu.DEFlush", DEFlush, 1);
      @(negedge CLK);
      applyStimulus(0, 5, 0, 2'b01, 0, 0, 0, 1, 5);
      #1;
      checkOutput("lu.StallCnt", StallCnt, 1);
      checkOutput("lu.DEMuxS",   DEMuxS,   2'b01);
      checkOutput("lu.IFStall2", IFStall,  0);
      checkOutput("lu.bubbleEx", EXWMMuxS, 0);
      @(negedge CLK);
      #1;
      checkOutput("lu.EXWMMuxS",  EXWMMuxS, 2'b01);
      checkOutput("lu.StallCnt2", StallCnt, 1);

      // Branch window: IFFlush T..T+2, DEFlush T+1..T+3, retry at T+2 ignored.
      doReset();
      applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      #1;
      checkOutput("br.IFFlush0", IFFlush, 1);
      checkOutput("br.DEFlush0", DEFlush, 0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLK);
         if (k == 2) applyStimulus(1, 5, 0, 2'b01, 1, 1, 5, 0, 0);
         else        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
         #1;
         checkOutput($sformatf("br.IFFlush%0d", k), IFFlush, (k <= 2) ? 1 : 0);
         checkOutput($sformatf("br.DEFlush%0d", k), DEFlush, (k <= 3) ? 1 : 0);
         checkOutput($sformatf("br.IFStall%0d", k), IFStall, 0);
      end
      checkOutput("br.FlushCnt", FlushCnt, 1);
      checkOutput("br.StallCnt", StallCnt, 0);

      // Branch together with a load-use hazard: stall first, accept next cycle.
      doReset();
      applyStimulus(1, 5, 0, 2'b01, 1, 1, 5, 0, 0);
      #1;
      checkOutput("bh.IFFlush1", IFFlush, 0);
      checkOutput("bh.IFStall1", IFStall, 1);
      @(negedge CLK);
      applyStimulus(1, 5, 0, 2'b01, 0, 0, 0, 1, 5);
      #1;
      checkOutput("bh.IFFlush2", IFFlush, 1);
      checkOutput("bh.IFStall2", IFStall, 0);
      checkOutput("bh.DEFlush2", DEFlush, 0);
      @(negedge CLK);
      applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      #1;
      checkOutput("bh.DEFlush3",  DEFlush,  1);
      checkOutput("bh.FlushCnt",  FlushCnt, 1);

      // Stall counter saturation at all-ones.
      doReset();
      applyStimulus(0, 5, 0, 2'b01, 1, 1, 5, 0, 0);
      repeat (5) @(negedge CLK);
      #1;
      checkOutput("sat.StallCnt5", StallCnt, 5);
      repeat (4) @(negedge CLK);
      #1;
      checkOutput("sat.StallCnt9", StallCnt, CNT_MAX);

      // Reset in the middle of a flush window.
      doReset();
      applyStimulus(0, 5, 0, 2'b01, 1, 1, 5, 0, 0);
      @(negedge CLK);
      applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      #1;
      checkOutput("rf.IFFlush", IFFlush, 1);
      @(negedge CLK);
      applyStimulus(0, 5, 5, 2'b11, 0, 0, 0, 1, 5);
      #1;
      checkOutput("rf.DEFlush",  DEFlush,  1);
      checkOutput("rf.FlushCnt", FlushCnt, 1);
      checkOutput("rf.StallCnt", StallCnt, 1);
      #1 rst = 1'b1;
      #1;
      checkOutput("rf.rIFFlush",  IFFlush,  0);
      checkOutput("rf.rDEFlush",  DEFlush,  0);
      checkOutput("rf.rIFStall",  IFStall,  0);
      checkOutput("rf.rDEMuxS",   DEMuxS,   0);
      checkOutput("rf.rEXWMMuxS", EXWMMuxS, 0);
      checkOutput("rf.rStallCnt", StallCnt, 0);
      checkOutput("rf.rFlushCnt", FlushCnt, 0);
      @(negedge CLK);
      rst = 1'b0;
      applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
      #1;
      checkOutput("rf.idleDEFlush", DEFlush, 0);
      checkOutput("rf.idleIFFlush", IFFlush, 0);

      // Randomized run against a reference model. The model tracks the flush
      // window by counting cycles since the last accepted branch.
      doReset();
      cyc        = 0;
      acceptCyc  = -100;
      stallCount = 0;
      flushCount = 0;
      for (int s = 0; s < NUM_SRC; s++) begin
         prevRs[s]   = '0;
         prevUsed[s] = 1'b0;
      end
      for (int n = 0; n < 1500; n++) begin
         rbr     = ($urandom_range(0, 3) == 0);
         srcA[0] = 5'($urandom_range(0, 3));
         srcA[1] = 5'($urandom_range(0, 3));
         ru      = 2'($urandom_range(0, 3));
         eR      = 1'($urandom_range(0, 1));
         eL      = ($urandom_range(0, 2) == 0);
         eD      = 5'($urandom_range(0, 3));
         wR      = 1'($urandom_range(0, 1));
         wD      = 5'($urandom_range(0, 3));
         applyStimulus(rbr, srcA[0], srcA[1], ru, eR, eL, eD, wR, wD);
         #1;
         sinceAcc = cyc - acceptCyc;
         inFlush  = (sinceAcc >= 1) && (sinceAcc <= BR);
         hzm      = 1'b0;
         expMux   = 0;
         expExMux = 0;
         for (int s = 0; s < NUM_SRC; s++) begin
            bit m1;
            bit m2;
            bit st;
            m1 = ru[s] && (srcA[s] != 0) && eR && (eD == srcA[s]);
            m2 = ru[s] && (srcA[s] != 0) && wR && (wD == srcA[s]);
            st = m1 && (eL || (FWD_EX == 0));
            if (st) hzm = 1'b1;
            if (m1 && !st)  expMux += 2 << (2 * s);
            else if (m2)    expMux += 1 << (2 * s);
            if (prevUsed[s] && (prevRs[s] != 0) && wR && (wD == prevRs[s])) expExMux += 1 << s;
         end
         expStall = !inFlush && hzm;
         expDEFl  = inFlush || hzm;
         expIFFl  = inFlush ? (sinceAcc < BR) : (rbr && !hzm);
         accept   = !inFlush && rbr && !hzm;
         checkOutput($sformatf("rnd%0d.IFFlush", n),  IFFlush,  expIFFl);
         checkOutput($sformatf("rnd%0d.DEFlush", n),  DEFlush,  expDEFl);
         checkOutput($sformatf("rnd%0d.IFStall", n),  IFStall,  expStall);
         checkOutput($sformatf("rnd%0d.DEMuxS", n),   DEMuxS,   expMux);
         checkOutput($sformatf("rnd%0d.EXWMMuxS", n), EXWMMuxS, expExMux);
         checkOutput($sformatf("rnd%0d.StallCnt", n), StallCnt, stallCount);
         checkOutput($sformatf("rnd%0d.FlushCnt", n), FlushCnt, flushCount);
         if (accept) begin
            acceptCyc = cyc;
            if (flushCount < CNT_MAX) flushCount++;
         end
         if (expStall && (stallCount < CNT_MAX)) stallCount++;
         for (int s = 0; s < NUM_SRC; s++) begin
            prevRs[s]   = srcA[s];
            prevUsed[s] = ru[s] && !expDEFl;
         end
         cyc++;
         @(negedge CLK);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
